pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. It is the wide successor to the 4-bit lookahead adder slice.
- Splits a WIDTH-bit operation into SLICE-bit pipeline stages.
- Inside each stage, carries come from 4-bit group propagate/generate lookahead.
- Sits between the register-read and writeback paths of the ALU. Uses a valid/ready handshake and reports carry, signed overflow and zero flags.

---
 rtl/pipelined_cla_adder.sv | 164 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit carry-lookahead add/sub, SLICE bits per stage, latency NSTAGE, valid/ready with global stall.
// Optional clamp-on-signed-overflow enabled by defining ADDER_SAT_EN.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_bit1,
    input  logic [WIDTH-1:0] i_bit2,
    input  logic             i_carry,
    input  logic             i_sub,
    input  logic             i_sat,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);
    localparam int NSTAGE = WIDTH / SLICE;
    localparam int NGRP   = SLICE / 4;
    localparam int L      = NSTAGE - 1;

    if ((WIDTH % SLICE) != 0 || (SLICE % 4) != 0 || SLICE < 4) begin : g_bad_param
        $error("pipelined_cla_adder: WIDTH must be a multiple of SLICE, SLICE a multiple of 4");
    end

    // Two-level lookahead: group carries as flat sum-of-products over group P/G, then bit carries inside each group.
    function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic cin);
        logic [SLICE-1:0] p, g, s;
        logic [NGRP-1:0]  gp, gg;
        logic [NGRP:0]    gc, gcx;
        logic [4:0]       gx;
        logic [3:0]       px;
        logic             t, c;
        p = a ^ b;
        g = a & b;
        s = '0;
        for (int j = 0; j < NGRP; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (&p[4*j+2 +: 2] & g[4*j+1])
                  | (&p[4*j+1 +: 3] & g[4*j]);
        end
        gcx = {gg, cin};
        for (int j = 0; j <= NGRP; j++) begin
            gc[j] = 1'b0;
            for (int i = 0; i <= j; i++) begin
                t = gcx[i];
                for (int m = i; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NGRP; j++) begin
            gx = {g[4*j +: 4], gc[j]};
            px = p[4*j +: 4];
            for (int n = 0; n < 4; n++) begin
                c = 1'b0;
                for (int i = 0; i <= n; i++) begin
                    t = gx[i];
                    for (int m = i; m < n; m++) t = t & px[m];
                    c = c | t;
                end
                s[4*j+n] = px[n] ^ c;
            end
        end
        return {gc[NGRP], s};
    endfunction

    logic              adv;
    logic              cin;
    logic [WIDTH-1:0]  b_eff;
    logic [NSTAGE-1:0] v_q;
    logic [NSTAGE-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [NSTAGE];
    logic [WIDTH-1:0]  b_q [NSTAGE];
    logic [WIDTH-1:0]  s_q [NSTAGE];
    logic [WIDTH-1:0]  s_d [NSTAGE];
    logic [SLICE:0]    r;
    logic [WIDTH-1:0]  wrap_sum, fin_sum;
    logic              ovf_d;

    logic              o_valid_q, o_carry_q, o_ovf_q, o_zero_q;
    logic [WIDTH-1:0]  o_sum_q;

    assign adv     = ~o_valid_q | i_ready;
    assign o_ready = adv & ~i_rst;
    assign b_eff   = i_sub ? ~i_bit2 : i_bit2;
    assign cin     = i_sub | i_carry;

    // Stage k finishes slice k; lower slices ride along already summed, upper operand bits wait their turn.
    always_comb begin
        r   = '0;
        c_d = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            r = cla_slice(a_q[k][k*SLICE +: SLICE], b_q[k][k*SLICE +: SLICE], c_q[k]);
            s_d[k] = s_q[k];
            s_d[k][k*SLICE +: SLICE] = r[SLICE-1:0];
            c_d[k] = r[SLICE];
        end
    end

    assign wrap_sum = s_d[L];
    assign ovf_d    = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) & (wrap_sum[WIDTH-1] != a_q[L][WIDTH-1]);

`ifdef ADDER_SAT_EN
    logic [NSTAGE-1:0] sat_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst && adv) begin
            sat_q[0] <= i_sat;
            for (int k = 1; k < NSTAGE; k++) sat_q[k] <= sat_q[k-1];
        end
    end

    // Overflow direction follows the shared operand sign: both positive can only overflow upward.
    assign fin_sum = (sat_q[L] & ovf_d)
                   ? (a_q[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                   : wrap_sum;
`else
    logic unused_sat;
    assign unused_sat = i_sat;
    assign fin_sum    = wrap_sum;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q        <= '0;
            o_valid_q  <= 1'b0;
            o_sum_q    <= '0;
            o_carry_q  <= 1'b0;
            o_ovf_q    <= 1'b0;
            o_zero_q   <= 1'b0;
        end else if (adv) begin
            v_q[0] <= i_valid;
            a_q[0] <= i_bit1;
            b_q[0] <= b_eff;
            s_q[0] <= '0;
            c_q[0] <= cin;
            for (int k = 1; k < NSTAGE; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_d[k-1];
                c_q[k] <= c_d[k-1];
            end
            o_valid_q <= v_q[L];
            o_sum_q   <= fin_sum;
            o_carry_q <= c_d[L];
            o_ovf_q   <= ovf_d;
            o_zero_q  <= ~|fin_sum;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_sum      = o_sum_q;
    assign o_carry    = o_carry_q;
    assign o_overflow = o_ovf_q;
    assign o_zero     = o_zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=32, SLICE=8): arithmetic reference model, decoupled monitor.
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

`ifdef ADDER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, i_carry, i_sub, i_sat, o_valid, i_ready;
    logic        o_carry, o_overflow, o_zero;
    logic [31:0] i_bit1, i_bit2, o_sum;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   rnd_on = 1'b0;

    always #5 i_clk = ~i_clk;

    pipelined_cla_adder #(.WIDTH(32), .SLICE(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_bit1(i_bit1), .i_bit2(i_bit2), .i_carry(i_carry), .i_sub(i_sub), .i_sat(i_sat),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_carry(o_carry),
        .o_overflow(o_overflow), .o_zero(o_zero)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain wide integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input logic sat);
        exp_t   e;
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ur  = ua - ub;
            sr  = sa - sb;
            e.c = (a >= b);
        end else begin
            ur  = ua + ub + longint'(cin);
            sr  = sa + sb + longint'(cin);
            e.c = (ur > 64'sd4294967295);
        end
        e.sum = ur[31:0];
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (SAT_EN && sat && e.v) e.sum = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.z = (e.sum == 32'h0);
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic t);
        int w;
        i_bit1 = a; i_bit2 = b; i_carry = c; i_sub = s; i_sat = t; i_valid = 1'b1;
        w = 0;
        @(negedge i_clk);
        while (o_ready !== 1'b1 && w < 50) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            w++;
        end
        if (o_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: o_ready stuck at %b, required 1", o_ready);
        end else begin
            q.push_back(model(a, b, c, s, t));
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 300) begin
            @(posedge i_clk); #1;
            w++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge i_clk) begin
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            n_out++;
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_result: got sum %h with nothing outstanding, required none", o_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result{sum,c,v,z}", 64'({o_sum, o_carry, o_overflow, o_zero}), 64'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          saved;
        logic [31:0] held;

        i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        i_bit1 = 32'h1234_5678; i_bit2 = 32'h1; i_carry = 1'b0; i_sub = 1'b0; i_sat = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_sum", 64'(o_sum), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        @(posedge i_clk); #1;
        chk("rst_valid2", 64'(o_valid), 64'd0);
        chk("rst_ready2", 64'(o_ready), 64'd0);
        i_rst = 1'b0; i_valid = 1'b0;
        @(negedge i_clk);
        chk("ready_after_rst", 64'(o_ready), 64'd1);
        chk("valid_after_rst", 64'(o_valid), 64'd0);
        @(posedge i_clk); #1;

        // Carry ripples through every stage; result must appear exactly 4 edges after acceptance.
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (o_valid !== 1'b1 && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'd4);

        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
        send(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        send(32'd9, 32'd9, 1'b0, 1'b1, 1'b0);
        send(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        wait_drain();

        // Back-to-back beats with a 3-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (6) @(posedge i_clk);
                #1 i_ready = 1'b0;
                @(negedge i_clk);
                held = o_sum;
                chk("stall_valid", 64'(o_valid), 64'd1);
                chk("stall_ready", 64'(o_ready), 64'd0);
                for (int i = 0; i < 2; i++) begin
                    @(negedge i_clk);
                    chk("stall_ready", 64'(o_ready), 64'd0);
                    chk("stall_hold", 64'(o_sum), 64'(held));
                end
                @(posedge i_clk); #1;
                i_ready = 1'b1;
            end
        join
        wait_drain();

        // Random traffic with random gaps and random downstream backpressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom));
                    if ($urandom_range(3) == 0) begin
                        @(posedge i_clk); #1;
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge i_clk); #1;
                    i_ready = ($urandom_range(3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        wait_drain();

        // Three beats in flight, then a one-cycle reset: none of them may ever emerge.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h1, 1'b0, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        q.delete();
        saved = n_out;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("valid_after_midrst", 64'(o_valid), 64'd0);
        repeat (12) @(posedge i_clk);
        #1;
        chk("no_stale_results", 64'(n_out), 64'(saved));

        @(posedge i_clk); #1;
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
